// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state type and constants for the FIFO drain controller
package fifo_reader_pkg;
  typedef enum logic [1:0] {IDLE, READ, STOPPING} rd_state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: two-entry in-order buffer allowing same-cycle write and pop at any occupancy
module skid_buf2
  import fifo_reader_pkg::*;
#(
  parameter int W = 8,
  localparam int OW = $clog2(SKID_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  head,
  output logic [OW-1:0] occ
);
  logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [OW-1:0] occ_q, occ_d, wr_idx;
  logic pop;
  always_comb begin
    pop = rd_en && occ_q != '0;
    wr_idx = occ_q - OW'(pop);
    occ_d = wr_idx + OW'(wr_en);
    mem0_d = (wr_en && wr_idx == '0) ? wr_data : pop ? mem1_q : mem0_q;
    mem1_d = (wr_en && wr_idx == OW'(1)) ? wr_data : mem1_q;
    head = mem0_q;
    occ = occ_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      occ_q <= '0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops an upstream FIFO into a skid buffer and emits fixed-length frames downstream
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN = 4,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_empty,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_full,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_dv,
  output logic                  o_last,
  output logic [FCNT_WIDTH-1:0] o_frame_cnt,
  output logic                  o_busy
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  rd_state_t state_q, state_d;
  logic rd_pend_q, xfer;
  logic [1:0] occ;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
  logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  skid_buf2 #(.W(DATA_WIDTH)) u_skid (
    .clk(i_clk),
    .rst(i_rst),
    .wr_en(rd_pend_q),
    .wr_data(i_data),
    .rd_en(xfer),
    .head(o_data),
    .occ(occ)
  );
  always_comb begin
    o_dv = occ != '0;
    xfer = o_dv && !i_full;
    o_last = o_dv && out_cnt_q == LAST;
    o_rd_en = (state_q == READ || (state_q == STOPPING && rd_cnt_q != '0)) && !i_empty
              && (occ - 2'(xfer)) + 2'(rd_pend_q) < 2'd2;
    rd_cnt_d = o_rd_en ? (rd_cnt_q == LAST ? '0 : rd_cnt_q + 1'b1) : rd_cnt_q;
    out_cnt_d = xfer ? (o_last ? '0 : out_cnt_q + 1'b1) : out_cnt_q;
    frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(xfer && o_last);
    state_d = i_en ? READ : (state_q == IDLE || rd_cnt_d == '0) ? IDLE : STOPPING;
    o_busy = state_q != IDLE || o_dv;
    o_frame_cnt = frame_cnt_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rd_pend_q <= 1'b0;
      rd_cnt_q <= '0;
      out_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rd_pend_q <= o_rd_en;
      rd_cnt_q <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and randomized checks of fifo_reader against a queue-based stream model
module tb_fifo_reader;
  logic clk = 1'b0;
  logic rst, en, empty, full;
  logic [7:0] din;
  logic rd_en, dv, last, busy;
  logic [7:0] dout;
  logic [15:0] fcnt;
  logic rd_en2, dv2, last2, busy2;
  logic [7:0] dout2;
  logic [1:0] fcnt2;
  int tests, fails, cyc, n_pop, n_xfer, gap_left, full_pct, gap_pct, full_from, full_to;
  int first_pop, last_pop, first_dv, last_dv, stall_01, win_pops;
  logic [7:0] up[$];
  logic [7:0] exp_q[$];
  bit pend, prev_stall, tb_en, tb_rst, gap_done;
  logic [7:0] pend_w, prev_data;
  logic prev_last;
  always #5 clk = ~clk;
  fifo_reader #(.DATA_WIDTH(8), .FRAME_LEN(4), .FCNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_empty(empty), .o_rd_en(rd_en), .i_data(din),
    .i_full(full), .o_data(dout), .o_dv(dv), .o_last(last), .o_frame_cnt(fcnt), .o_busy(busy)
  );
  fifo_reader #(.DATA_WIDTH(8), .FRAME_LEN(4), .FCNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_empty(empty), .o_rd_en(rd_en2), .i_data(din),
    .i_full(full), .o_data(dout2), .o_dv(dv2), .o_last(last2), .o_frame_cnt(fcnt2), .o_busy(busy2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    bit popped, xf;
    logic [7:0] w;
    @(negedge clk);
    cyc++;
    rst = tb_rst;
    en = tb_en;
    din = pend ? pend_w : 8'($urandom);
    full = (cyc >= full_from && cyc <= full_to) || ($urandom_range(99) < full_pct);
    empty = gap_left > 0 || up.size() == 0 || ($urandom_range(99) < gap_pct);
    if (gap_left > 0) gap_left--;
    #1;
    popped = rd_en && !empty;
    xf = dv && !full;
    if (empty) chk("rd_en_while_empty", 32'(rd_en), 0);
    if (prev_stall) begin
      chk("stall_dv", 32'(dv), 1);
      chk("stall_data", 32'(dout), 32'(prev_data));
      chk("stall_last", 32'(last), 32'(prev_last));
    end
    if (dv) begin
      chk("data", 32'(dout), exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hx);
      chk("busy_dv", 32'(busy), 1);
    end
    chk("last", 32'(last), 32'(dv && n_xfer % 4 == 3));
    chk("fcnt", 32'(fcnt), n_xfer / 4);
    chk("fcnt2", 32'(fcnt2), (n_xfer / 4) % 4);
    if (dv && full && dout == 8'h01) stall_01++;
    prev_stall = dv && full && !rst;
    prev_data = dout;
    prev_last = last;
    if (xf) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      n_xfer++;
      if (first_dv < 0) first_dv = cyc;
      last_dv = cyc;
    end
    pend = 1'b0;
    if (popped) begin
      w = up.pop_front();
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (!rst) begin
        exp_q.push_back(w);
        pend = 1'b1;
        pend_w = w;
      end
    end
    if (rst) begin
      exp_q.delete();
      n_xfer = 0;
      prev_stall = 1'b0;
    end
  endtask
  task automatic begin_test();
    tb_en = 1'b0;
    tb_rst = 1'b1;
    up.delete();
    full_pct = 0;
    gap_pct = 0;
    gap_left = 0;
    full_from = -1;
    full_to = -2;
    step();
    tb_rst = 1'b0;
    n_pop = 0;
    first_pop = -1;
    last_pop = -1;
    first_dv = -1;
    last_dv = -1;
    stall_01 = 0;
    win_pops = -1;
    gap_done = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    empty = 1'b1;
    full = 1'b0;
    din = '0;
    begin_test();
    step();
    chk("rst_dv", 32'(dv), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_data", 32'(dout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_fcnt", 32'(fcnt), 0);
    begin_test();
    for (int i = 1; i <= 8; i++) up.push_back(8'(i));
    tb_en = 1'b1;
    repeat (16) step();
    chk("t1_npop", n_pop, 8);
    chk("t1_pop_run", last_pop - first_pop + 1, 8);
    chk("t1_latency", first_dv - first_pop, 2);
    chk("t1_dv_run", last_dv - first_dv + 1, 8);
    chk("t1_nxfer", n_xfer, 8);
    chk("t1_fcnt", 32'(fcnt), 2);
    begin_test();
    for (int i = 1; i <= 8; i++) up.push_back(8'(i));
    tb_en = 1'b1;
    repeat (24) begin
      step();
      if (first_pop >= 0 && full_from < 0) begin
        full_from = first_pop + 2;
        full_to = first_pop + 6;
      end
      if (cyc == full_to) win_pops = n_pop;
    end
    chk("t2_stall_01", stall_01, 5);
    chk("t2_pops_in_stall", win_pops, 2);
    chk("t2_nxfer", n_xfer, 8);
    chk("t2_fcnt", 32'(fcnt), 2);
    begin_test();
    for (int i = 1; i <= 10; i++) up.push_back(8'(i));
    tb_en = 1'b1;
    repeat (20) begin
      step();
      if (n_pop >= 2) tb_en = 1'b0;
    end
    chk("t3_npop", n_pop, 4);
    chk("t3_left", up.size(), 6);
    chk("t3_nxfer", n_xfer, 4);
    chk("t3_fcnt", 32'(fcnt), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_rd_en", 32'(rd_en), 0);
    begin_test();
    for (int i = 1; i <= 4; i++) up.push_back(8'(i));
    tb_en = 1'b1;
    repeat (20) begin
      step();
      if (n_pop == 2 && !gap_done) begin
        gap_left = 3;
        gap_done = 1'b1;
      end
    end
    chk("t4_npop", n_pop, 4);
    chk("t4_nxfer", n_xfer, 4);
    chk("t4_fcnt", 32'(fcnt), 1);
    chk("t4_pending", exp_q.size(), 0);
    begin_test();
    for (int i = 1; i <= 8; i++) up.push_back(8'(i));
    tb_en = 1'b1;
    for (int i = 0; i < 10 && n_pop < 3; i++) step();
    chk("t5_pops", n_pop, 3);
    tb_rst = 1'b1;
    tb_en = 1'b0;
    step();
    tb_rst = 1'b0;
    step();
    chk("t5_dv", 32'(dv), 0);
    chk("t5_fcnt", 32'(fcnt), 0);
    chk("t5_busy", 32'(busy), 0);
    up.delete();
    for (int i = 0; i < 4; i++) up.push_back(8'(8'hA0 + i));
    tb_en = 1'b1;
    repeat (14) step();
    chk("t5_nxfer", n_xfer, 4);
    chk("t5_fcnt_after", 32'(fcnt), 1);
    chk("t5_pending", exp_q.size(), 0);
    begin_test();
    repeat (20) up.push_back(8'($urandom));
    full_pct = 30;
    gap_pct = 25;
    tb_en = 1'b1;
    repeat (200) step();
    full_pct = 0;
    gap_pct = 0;
    repeat (10) step();
    chk("t6_nxfer", n_xfer, 20);
    chk("t6_fcnt", 32'(fcnt), 5);
    chk("t6_fcnt2", 32'(fcnt2), 1);
    chk("t6_pending", exp_q.size(), 0);
    begin_test();
    full_pct = 20;
    gap_pct = 10;
    tb_en = 1'b1;
    repeat (300) begin
      if (up.size() < 4) up.push_back(8'($urandom));
      if ($urandom_range(9) == 0) tb_en = !tb_en;
      step();
    end
    tb_en = 1'b0;
    full_pct = 0;
    gap_pct = 0;
    repeat (8) up.push_back(8'($urandom));
    repeat (20) step();
    chk("t7_frame_aligned", n_pop % 4, 0);
    chk("t7_all_out", n_xfer, n_pop);
    chk("t7_pending", exp_q.size(), 0);
    chk("t7_busy", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
